// File: rtl/tracer_pkg.sv
// rtl/tracer_pkg.sv - shared constants, state encoding and lane-width helper for the tracer
package tracer_pkg;

    localparam int TRB_WIDTH       = 64;
    localparam int TRB_MAX_TRACES  = 8;
    localparam int TRB_NTRACE_BITS = 2;
    localparam int TRB_POS_BITS    = $clog2(TRB_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        STOPPED,
        S_WAIT,
        S_RUN
    } tracer_state_t;

    // One extra bit so a full-word advance is visible as a carry out of the pointer.
    function automatic logic [TRB_POS_BITS:0] lane_width(input logic [TRB_NTRACE_BITS-1:0] n);
        return (TRB_POS_BITS+1)'(1) << n;
    endfunction

endpackage

// File: rtl/tracer_if.sv
// rtl/tracer_if.sv - tracer <-> trace-buffer logger word transfer bus
interface tracer_if;
    import tracer_pkg::*;

    logic [TRB_WIDTH-1:0] DATA_O;
    logic                 STORE_O;
    logic                 STORE_PERM_I;
    logic                 TRG_DELAYED_I;
    logic [TRB_WIDTH-1:0] DATA_I;
    logic                 LOAD_REQUEST_O;
    logic                 LOAD_GRANT_I;

    modport master (
        output DATA_O, STORE_O, LOAD_REQUEST_O,
        input  STORE_PERM_I, TRG_DELAYED_I, DATA_I, LOAD_GRANT_I
    );

    modport slave (
        input  DATA_O, STORE_O, LOAD_REQUEST_O,
        output STORE_PERM_I, TRG_DELAYED_I, DATA_I, LOAD_GRANT_I
    );

endinterface

// File: rtl/trace_unpacker.sv
// rtl/trace_unpacker.sv - double-buffered word fetch and lane replay for streaming mode
module trace_unpacker
    import tracer_pkg::*;
(
    input  logic                       CLK_I,
    input  logic                       RST_I,
    input  logic                       stream_active,
    input  logic                       stream_run,
    input  logic [TRB_NTRACE_BITS-1:0] n_q,
    input  logic [TRB_WIDTH-1:0]       DATA_I,
    input  logic                       LOAD_GRANT_I,
    output logic                       LOAD_REQUEST_O,
    output logic [TRB_MAX_TRACES-1:0]  TRACE_O,
    output logic                       TRACE_VALID_O,
    output logic                       cur_valid,
    output logic                       rpos_wrap,
    output logic                       underrun
);

    logic [TRB_WIDTH-1:0]      cur_q;
    logic [TRB_WIDTH-1:0]      nxt_q;
    logic                      nxt_valid;
    logic                      pending;
    logic [TRB_POS_BITS-1:0]   rpos_q;
    logic [TRB_POS_BITS:0]     k;
    logic [TRB_POS_BITS:0]     rpos_sum;
    logic                      grant;
    logic                      cur_free;
    logic [TRB_MAX_TRACES-1:0] lane_d;

    assign k         = lane_width(n_q);
    assign rpos_sum  = {1'b0, rpos_q} + k;
    assign rpos_wrap = stream_run && rpos_sum[TRB_POS_BITS];
    assign grant     = LOAD_GRANT_I && pending;
    assign underrun  = rpos_wrap && !nxt_valid && !grant;
    // cur counts as free when it drains this cycle with nothing queued behind it
    assign cur_free  = !cur_valid || (rpos_wrap && !nxt_valid);

    always_comb begin
        lane_d = '0;
        for (int i = 0; i < TRB_MAX_TRACES; i++) begin
            if (i < int'(k)) begin
                lane_d[i] = cur_q[rpos_q + TRB_POS_BITS'(i)];
            end
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            cur_q          <= '0;
            nxt_q          <= '0;
            cur_valid      <= 1'b0;
            nxt_valid      <= 1'b0;
            pending        <= 1'b0;
            rpos_q         <= '0;
            LOAD_REQUEST_O <= 1'b0;
            TRACE_O        <= '0;
            TRACE_VALID_O  <= 1'b0;
        end else begin
            LOAD_REQUEST_O <= 1'b0;
            if (stream_active && !nxt_valid && !pending) begin
                LOAD_REQUEST_O <= 1'b1;
                pending        <= 1'b1;
            end
            if (grant) begin
                pending <= 1'b0;
            end

            if (stream_run) begin
                TRACE_O       <= lane_d;
                TRACE_VALID_O <= 1'b1;
                rpos_q        <= rpos_sum[TRB_POS_BITS-1:0];
            end else begin
                TRACE_O       <= '0;
                TRACE_VALID_O <= 1'b0;
            end

            if (rpos_wrap && nxt_valid) begin
                cur_q     <= nxt_q;
                nxt_valid <= 1'b0;
            end else if (rpos_wrap) begin
                cur_valid <= 1'b0;
            end

            if (grant) begin
                if (cur_free) begin
                    cur_q     <= DATA_I;
                    cur_valid <= 1'b1;
                end else begin
                    nxt_q     <= DATA_I;
                    nxt_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tracer.sv
// rtl/tracer.sv - trace capture packer, trigger recorder and mode state machine
module tracer
    import tracer_pkg::*;
(
    input  logic                       CLK_I,
    input  logic                       RST_I,
    input  logic [TRB_MAX_TRACES-1:0]  TRACE_I,
    input  logic                       TRIGGER_I,
    input  logic                       MODE_I,
    input  logic [TRB_NTRACE_BITS-1:0] NTRACE_I,
    tracer_if.master                   lgr,
    output logic                       TRG_EVENT_O,
    output logic [TRB_POS_BITS-1:0]    EVENT_POS_O,
    output logic                       OVERFLOW_O,
    output logic [TRB_MAX_TRACES-1:0]  TRACE_O,
    output logic                       TRACE_VALID_O
);

    tracer_state_t              state_q;
    tracer_state_t              state_d;
    logic [TRB_NTRACE_BITS-1:0] n_q;
    logic [TRB_POS_BITS-1:0]    wpos_q;
    logic [TRB_POS_BITS:0]      k;
    logic [TRB_POS_BITS:0]      wpos_sum;
    logic [TRB_WIDTH-1:0]       shift_q;
    logic [TRB_WIDTH-1:0]       word_d;
    logic [TRB_WIDTH-1:0]       data_q;
    logic                       store_q;
    logic                       sample;
    logic                       wpos_wrap;
    logic                       rpos_wrap;
    logic                       cur_valid;
    logic                       underrun;
    logic                       stream_active;
    logic                       stream_run;

    assign k             = lane_width(n_q);
    assign sample        = (state_q == CAPTURE) && !lgr.TRG_DELAYED_I;
    assign wpos_sum      = {1'b0, wpos_q} + k;
    // wpos stays aligned to k, so a carry out means exactly one full word
    assign wpos_wrap     = sample && wpos_sum[TRB_POS_BITS];
    assign stream_active = (state_q == S_WAIT) || (state_q == S_RUN);
    assign stream_run    = (state_q == S_RUN);

    assign lgr.DATA_O  = data_q;
    assign lgr.STORE_O = store_q;

    always_comb begin
        word_d = shift_q;
        for (int i = 0; i < TRB_MAX_TRACES; i++) begin
            if (i < int'(k)) begin
                word_d[wpos_q + TRB_POS_BITS'(i)] = TRACE_I[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = MODE_I ? S_WAIT : CAPTURE;
            CAPTURE: if (lgr.TRG_DELAYED_I) state_d = STOPPED;
            S_WAIT:  if (cur_valid) state_d = S_RUN;
            S_RUN:   if (underrun) state_d = S_WAIT;
            default: ;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            n_q         <= '0;
            wpos_q      <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            store_q     <= 1'b0;
            TRG_EVENT_O <= 1'b0;
            EVENT_POS_O <= '0;
            OVERFLOW_O  <= 1'b0;
        end else begin
            store_q <= 1'b0;
            if (state_q == IDLE || wpos_wrap || rpos_wrap) begin
                n_q <= NTRACE_I;
            end
            if (sample) begin
                shift_q <= word_d;
                wpos_q  <= wpos_sum[TRB_POS_BITS-1:0];
                if (TRIGGER_I && !TRG_EVENT_O) begin
                    TRG_EVENT_O <= 1'b1;
                    EVENT_POS_O <= wpos_q;
                end
                if (wpos_wrap) begin
                    if (lgr.STORE_PERM_I) begin
                        data_q  <= word_d;
                        store_q <= 1'b1;
                    end else begin
                        OVERFLOW_O <= 1'b1;
                    end
                end
            end
        end
    end

    trace_unpacker u_unpacker (
        .CLK_I          (CLK_I),
        .RST_I          (RST_I),
        .stream_active  (stream_active),
        .stream_run     (stream_run),
        .n_q            (n_q),
        .DATA_I         (lgr.DATA_I),
        .LOAD_GRANT_I   (lgr.LOAD_GRANT_I),
        .LOAD_REQUEST_O (lgr.LOAD_REQUEST_O),
        .TRACE_O        (TRACE_O),
        .TRACE_VALID_O  (TRACE_VALID_O),
        .cur_valid      (cur_valid),
        .rpos_wrap      (rpos_wrap),
        .underrun       (underrun)
    );

endmodule

// File: tb/tb_tracer.sv
// tb/tb_tracer.sv - scoreboard bench for tracer capture and streaming modes
module tb_tracer;
    import tracer_pkg::*;

    logic                       CLK_I = 1'b0;
    logic                       RST_I = 1'b1;
    logic [TRB_MAX_TRACES-1:0]  TRACE_I = '0;
    logic                       TRIGGER_I = 1'b0;
    logic                       MODE_I = 1'b0;
    logic [TRB_NTRACE_BITS-1:0] NTRACE_I = '0;
    logic                       TRG_EVENT_O;
    logic [TRB_POS_BITS-1:0]    EVENT_POS_O;
    logic                       OVERFLOW_O;
    logic [TRB_MAX_TRACES-1:0]  TRACE_O;
    logic                       TRACE_VALID_O;

    tracer_if lg();

    tracer dut (
        .CLK_I         (CLK_I),
        .RST_I         (RST_I),
        .TRACE_I       (TRACE_I),
        .TRIGGER_I     (TRIGGER_I),
        .MODE_I        (MODE_I),
        .NTRACE_I      (NTRACE_I),
        .lgr           (lg),
        .TRG_EVENT_O   (TRG_EVENT_O),
        .EVENT_POS_O   (EVENT_POS_O),
        .OVERFLOW_O    (OVERFLOW_O),
        .TRACE_O       (TRACE_O),
        .TRACE_VALID_O (TRACE_VALID_O)
    );

    always #5 CLK_I = ~CLK_I;

    int checks = 0;
    int errors = 0;

    logic [TRB_WIDTH-1:0]      exp_store_q[$];
    logic [TRB_MAX_TRACES-1:0] exp_lane_q[$];
    logic [TRB_WIDTH-1:0]      words_q[$];
    int s_k = 1;
    int fixed_lat = 1;
    bit gap_en = 1'b0;
    bit prev_valid = 1'b0;

    logic [TRB_WIDTH-1:0] m_word;
    int m_pos, m_k, m_epos;
    bit m_trg, m_ovf, m_stop;

    task automatic chk(input string name, input logic [TRB_WIDTH-1:0] got, input logic [TRB_WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every presented output is matched against the scoreboard queues.
    always @(negedge CLK_I) begin
        if (RST_I) begin
            prev_valid = 1'b0;
        end else begin
            if (gap_en && prev_valid && exp_lane_q.size() > 0)
                chk("stream_gap", TRACE_VALID_O, 1);
            if (lg.STORE_O) begin
                if (exp_store_q.size() == 0) chk("store_unexpected", lg.STORE_O, 0);
                else chk("store_data", lg.DATA_O, exp_store_q.pop_front());
            end
            if (TRACE_VALID_O) begin
                if (exp_lane_q.size() == 0) chk("trace_unexpected", TRACE_VALID_O, 0);
                else chk("trace_lane", TRACE_O, exp_lane_q.pop_front());
            end
            prev_valid = TRACE_VALID_O;
        end
    end

    // Logger responder: grants queued words after a latency and records the lanes they carry.
    initial begin
        int wait_cnt;
        logic [TRB_WIDTH-1:0] w;
        logic [TRB_MAX_TRACES-1:0] lane;
        wait_cnt = -1;
        lg.LOAD_GRANT_I = 1'b0;
        lg.DATA_I = '0;
        forever begin
            @(negedge CLK_I);
            lg.LOAD_GRANT_I = 1'b0;
            if (RST_I) begin
                wait_cnt = -1;
            end else begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else if (wait_cnt == 0) begin
                    w = words_q.pop_front();
                    lg.DATA_I = w;
                    lg.LOAD_GRANT_I = 1'b1;
                    for (int j = 0; j < TRB_WIDTH / s_k; j++) begin
                        lane = '0;
                        for (int b = 0; b < s_k; b++) lane[b] = w[j*s_k + b];
                        exp_lane_q.push_back(lane);
                    end
                    wait_cnt = -1;
                end
                if (lg.LOAD_REQUEST_O && wait_cnt < 0 && words_q.size() > 0)
                    wait_cnt = ((fixed_lat > 0) ? fixed_lat : $urandom_range(1, 12)) - 1;
            end
        end
    end

    task automatic do_reset();
        @(posedge CLK_I);
        #2 RST_I = 1'b1;
        #1;
        chk("rst_data", lg.DATA_O, 0);
        chk("rst_store", lg.STORE_O, 0);
        chk("rst_trg", TRG_EVENT_O, 0);
        chk("rst_pos", EVENT_POS_O, 0);
        chk("rst_ovf", OVERFLOW_O, 0);
        chk("rst_req", lg.LOAD_REQUEST_O, 0);
        chk("rst_trace", TRACE_O, 0);
        chk("rst_tvalid", TRACE_VALID_O, 0);
        exp_store_q.delete();
        exp_lane_q.delete();
        words_q.delete();
        m_word = '0; m_pos = 0; m_epos = 0;
        m_trg = 0; m_ovf = 0; m_stop = 0;
    endtask

    // Releases reset at a falling edge; the following rising edge is the IDLE cycle.
    task automatic start(input logic mode, input int nt);
        chk("store_missing", exp_store_q.size(), 0);
        do_reset();
        @(negedge CLK_I);
        MODE_I = mode;
        NTRACE_I = 2'(nt);
        TRACE_I = '0;
        TRIGGER_I = 1'b0;
        lg.STORE_PERM_I = 1'b0;
        lg.TRG_DELAYED_I = 1'b0;
        RST_I = 1'b0;
        m_k = 1 << nt;
    endtask

    task automatic cap(input logic [7:0] tr, input logic trig, input logic perm, input logic dly, input int nt);
        @(negedge CLK_I);
        TRACE_I = tr;
        TRIGGER_I = trig;
        lg.STORE_PERM_I = perm;
        lg.TRG_DELAYED_I = dly;
        NTRACE_I = 2'(nt);
        if (!m_stop) begin
            if (dly) begin
                m_stop = 1;
            end else begin
                if (trig && !m_trg) begin
                    m_trg = 1;
                    m_epos = m_pos;
                end
                for (int b = 0; b < m_k; b++) m_word[m_pos + b] = tr[b];
                m_pos += m_k;
                if (m_pos == TRB_WIDTH) begin
                    if (perm) exp_store_q.push_back(m_word);
                    else m_ovf = 1;
                    m_pos = 0;
                    m_k = 1 << nt;
                end
            end
        end
    endtask

    task automatic finish_capture();
        cap(8'h0, 1'b0, 1'b1, 1'b1, 0);
        repeat (3) @(negedge CLK_I);
        chk("trg_event", TRG_EVENT_O, m_trg);
        if (m_trg) chk("event_pos", EVENT_POS_O, m_epos);
        chk("overflow", OVERFLOW_O, m_ovf);
    endtask

    task automatic stream_run(input int nt, input int nwords, input int lat, input bit gap, input bit fixed_first);
        s_k = 1 << nt;
        fixed_lat = lat;
        start(1'b1, nt);
        for (int i = 0; i < nwords; i++)
            words_q.push_back((fixed_first && i == 0) ? 64'h0706_0504_0302_0100 : {$urandom, $urandom});
        gap_en = gap;
        for (int c = 0; c < 3000 && (words_q.size() > 0 || exp_lane_q.size() > 0); c++)
            @(negedge CLK_I);
        chk("stream_drain", words_q.size() + exp_lane_q.size(), 0);
        repeat (20) @(negedge CLK_I);
        chk("stream_idle_valid", TRACE_VALID_O, 0);
        gap_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt, trig_at;
        lg.STORE_PERM_I = 1'b0;
        lg.TRG_DELAYED_I = 1'b0;

        // single-lane alternating pattern, upper lanes random noise
        start(1'b0, 0);
        for (int i = 0; i < 64; i++) cap({7'($urandom), (i % 2 == 0)}, 1'b0, 1'b1, 1'b0, 0);
        finish_capture();

        // eight lanes counting, then a second word while NTRACE wanders mid-word
        start(1'b0, 3);
        for (int i = 0; i < 8; i++) cap(8'(i), 1'b0, 1'b1, 1'b0, (i == 7) ? 3 : $urandom_range(0, 3));
        for (int i = 0; i < 8; i++) cap(8'($urandom), 1'b0, 1'b1, 1'b0, (i == 7) ? 3 : $urandom_range(0, 3));
        finish_capture();

        // trigger on 5th and 9th sample; stop right after a wrap so the pending store still lands
        start(1'b0, 2);
        for (int i = 0; i < 16; i++) cap(8'($urandom), (i == 4 || i == 8), 1'b1, 1'b0, 2);
        cap(8'($urandom), 1'b0, 1'b1, 1'b1, 2);
        for (int i = 0; i < 20; i++) cap(8'($urandom), 1'b1, 1'b1, 1'b0, 2);
        finish_capture();

        // dropped word, then a normal one; trigger on the wrap sample
        start(1'b0, 3);
        for (int i = 0; i < 8; i++) cap(8'($urandom), (i == 7), (i != 7), 1'b0, 3);
        for (int i = 0; i < 8; i++) cap(8'($urandom), 1'b0, 1'b1, 1'b0, 3);
        finish_capture();

        // mid-word asynchronous reset after stores and overflow, then a clean restart
        start(1'b0, 1);
        for (int i = 0; i < 32; i++) cap(8'($urandom), (i == 3), 1'b1, 1'b0, 1);
        for (int i = 0; i < 32; i++) cap(8'($urandom), 1'b0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 5; i++) cap(8'($urandom), 1'b0, 1'b1, 1'b0, 1);
        repeat (2) @(negedge CLK_I);
        start(1'b0, 1);
        for (int i = 0; i < 32; i++) cap(8'($urandom), 1'b0, 1'b1, 1'b0, 1);
        finish_capture();

        // randomized capture runs
        for (int r = 0; r < 4; r++) begin
            nt = $urandom_range(0, 3);
            trig_at = $urandom_range(0, 60);
            start(1'b0, nt);
            for (int i = 0; i < 120; i++)
                cap(8'($urandom), (i == trig_at) || ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 1'b0, $urandom_range(0, 3));
            finish_capture();
        end

        // streaming: prompt grants with no gaps, then withheld grant
        stream_run(3, 3, 1, 1'b1, 1'b1);
        // streaming: every lane width with random grant latency
        for (int n = 0; n < 4; n++) stream_run(n, 3, 0, 1'b0, 1'b0);

        chk("store_missing", exp_store_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
